leaf_rx_demux: RTL and testbench

- Receive-side leaf interface inside a DFX page.
- Consumes the 49-bit BFT leaf packet stream (din_leaf_bft2interface) delivered to a page, decodes the destination port, and steers the 32-bit payload into per-port first-word-fall-through (FWFT) FIFOs.
- The FIFOs present valid/ready streams to the page's operator logic.
- Gated by ap_start; reports drops, misroutes and busy status for debug and readback.

---
 rtl/leaf_pkt_pkg.sv | 36 +++
 rtl/leaf_rx_fifo.sv | 92 +++++++++
 rtl/leaf_rx_demux.sv | 200 ++++++++++++++++++++
 tb/tb_leaf_rx_demux.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// -----------------------------------------------------------------------------
// leaf_pkt_pkg
// Shared definitions for the BFT leaf receive path: the 49-bit leaf packet
// layout, the receive state encoding and small field-extraction helpers.
// Packet layout:
//   [48]    valid
//   [47:44] destination port
//   [43:32] reserved (ignored)
//   [31:0]  payload
// -----------------------------------------------------------------------------
package leaf_pkt_pkg;

    localparam int PKT_W      = 49;
    localparam int VALID_BIT  = 48;
    localparam int PORT_HI    = 47;
    localparam int PORT_LO    = 44;
    localparam int PORT_W     = PORT_HI - PORT_LO + 1;
    localparam int PAYLOAD_HI = 31;
    localparam int PAYLOAD_LO = 0;
    localparam int PKT_PAYLOAD_W = PAYLOAD_HI - PAYLOAD_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_e;

    function automatic logic [PORT_W-1:0] get_dest_port(input logic [PKT_W-1:0] pkt);
        return pkt[PORT_HI:PORT_LO];
    endfunction

    function automatic logic [PKT_PAYLOAD_W-1:0] get_payload(input logic [PKT_W-1:0] pkt);
        return pkt[PAYLOAD_HI:PAYLOAD_LO];
    endfunction

endpackage

// File: rtl/leaf_rx_fifo.sv
// -----------------------------------------------------------------------------
// leaf_rx_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always visible on
// pop_data while the FIFO is non-empty (zero when empty). A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
// Ports:
//   clk        clock
//   reset_n    synchronous active-low reset (empties the FIFO)
//   push       write request, push_data written on acceptance
//   pop        read request, head removed when non-empty
//   pop_data   head entry
//   full/empty registered status flags
//   count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module leaf_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_next_s;
    logic              empty_r;
    logic              full_r;
    logic              do_pop_s;
    logic              do_push_s;

    // Qualify requests: a pop needs data, a push needs room or a same-cycle pop.
    always_comb begin
        do_pop_s  = pop & ~empty_r;
        do_push_s = push & (~full_r | do_pop_s);
    end

    // Occupancy update; push+pop together leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and flags; flags are derived from the next occupancy
    // so they are registered and line up with count_r.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == {(ADDR_W+1){1'b0}});
            full_r  <= (count_next_s == (ADDR_W+1)'(DEPTH));
        end
    end

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (reset_n && do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = empty_r ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;

endmodule

// File: rtl/leaf_rx_demux.sv
// -----------------------------------------------------------------------------
// leaf_rx_demux
// Receive-side leaf interface of a DFX page. Samples the BFT leaf packet
// stream, decodes the destination port and steers the payload into one FWFT
// FIFO per output stream. Gated by ap_start through an IDLE/RUN/DRAIN FSM.
// Ports:
//   clk_400, reset_400        clock, synchronous active-low reset
//   ap_start                  level enable for packet acceptance
//   din_leaf_bft2interface    49-bit leaf packet
//   dout_stream_data/valid    per-port FWFT head data and valid
//   dout_stream_ready         per-port pop request
//   overflow                  sticky per-port drop-on-full flags
//   misroute                  sticky flag, destination port out of range
//   drop_count                saturating count of dropped packets
//   busy                      not IDLE, or any FIFO holds data
// Pipeline: stage 1 registers the packet, stage 2 decodes and writes the FIFO,
// so a packet sampled at one edge shows as valid two clocks later.
// -----------------------------------------------------------------------------
module leaf_rx_demux
    import leaf_pkt_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int PAYLOAD_W  = 32
) (
    input  logic                           clk_400,
    input  logic                           reset_400,
    input  logic                           ap_start,
    input  logic [PKT_W-1:0]               din_leaf_bft2interface,
    output logic [NUM_PORTS*PAYLOAD_W-1:0] dout_stream_data,
    output logic [NUM_PORTS-1:0]           dout_stream_valid,
    input  logic [NUM_PORTS-1:0]           dout_stream_ready,
    output logic [NUM_PORTS-1:0]           overflow,
    output logic                           misroute,
    output logic [15:0]                    drop_count,
    output logic                           busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_e              state_r;
    rx_state_e              state_next_s;

    logic                   sample_s;
    logic                   in_valid_r;
    logic [PORT_W-1:0]      in_port_r;
    logic [PAYLOAD_W-1:0]   in_payload_r;

    logic [NUM_PORTS-1:0]   push_s;
    logic [NUM_PORTS-1:0]   pop_s;
    logic [NUM_PORTS-1:0]   full_s;
    logic [NUM_PORTS-1:0]   empty_s;
    logic [CNT_W-1:0]       fifo_count_s [NUM_PORTS];
    logic                   fifos_idle_s;

    logic [NUM_PORTS-1:0]   ovf_hit_s;
    logic                   misroute_hit_s;
    logic                   drop_s;

    logic [NUM_PORTS-1:0]   overflow_r;
    logic                   misroute_r;
    logic [15:0]            drop_count_r;

    // True when every FIFO is empty.
    always_comb begin
        fifos_idle_s = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            fifos_idle_s = fifos_idle_s & (fifo_count_s[p] == {CNT_W{1'b0}});
        end
    end

    // Next-state logic. Leaving DRAIN waits for the stage-1 packet too, so a
    // late packet cannot land in a FIFO while the FSM already reports IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ap_start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!ap_start) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (ap_start) begin
                    state_next_s = ST_RUN;
                end else if (fifos_idle_s && !in_valid_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_400) begin
        if (!reset_400) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sampling stops on the very edge where the FSM leaves RUN.
    assign sample_s = (state_r == ST_RUN) & ap_start & din_leaf_bft2interface[VALID_BIT];

    // Stage 1 input register.
    always_ff @(posedge clk_400) begin
        if (!reset_400) begin
            in_valid_r   <= 1'b0;
            in_port_r    <= {PORT_W{1'b0}};
            in_payload_r <= {PAYLOAD_W{1'b0}};
        end else begin
            in_valid_r <= sample_s;
            if (sample_s) begin
                in_port_r    <= get_dest_port(din_leaf_bft2interface);
                in_payload_r <= PAYLOAD_W'(get_payload(din_leaf_bft2interface));
            end
        end
    end

    assign pop_s = dout_stream_ready & ~empty_s;

    // Stage 2 decode: route to a FIFO, or flag a misroute / full-FIFO drop.
    // A full FIFO still accepts when its head is popped in the same cycle.
    always_comb begin
        push_s         = {NUM_PORTS{1'b0}};
        ovf_hit_s      = {NUM_PORTS{1'b0}};
        misroute_hit_s = 1'b0;
        if (in_valid_r) begin
            if (32'(in_port_r) >= NUM_PORTS) begin
                misroute_hit_s = 1'b1;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (in_port_r == PORT_W'(p)) begin
                        if (full_s[p] && !pop_s[p]) begin
                            ovf_hit_s[p] = 1'b1;
                        end else begin
                            push_s[p] = 1'b1;
                        end
                    end else begin
                        push_s[p] = 1'b0;
                    end
                end
            end
        end else begin
            misroute_hit_s = 1'b0;
        end
    end

    assign drop_s = misroute_hit_s | (|ovf_hit_s);

    // Sticky flags and saturating drop counter; cleared only by reset.
    always_ff @(posedge clk_400) begin
        if (!reset_400) begin
            overflow_r   <= {NUM_PORTS{1'b0}};
            misroute_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else begin
            overflow_r <= overflow_r | ovf_hit_s;
            misroute_r <= misroute_r | misroute_hit_s;
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'h0001;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        leaf_rx_fifo #(
            .WIDTH (PAYLOAD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk_400),
            .reset_n   (reset_400),
            .push      (push_s[g]),
            .push_data (in_payload_r),
            .pop       (dout_stream_ready[g]),
            .pop_data  (dout_stream_data[g*PAYLOAD_W +: PAYLOAD_W]),
            .full      (full_s[g]),
            .empty     (empty_s[g]),
            .count     (fifo_count_s[g])
        );
    end

    assign dout_stream_valid = ~empty_s;
    assign overflow          = overflow_r;
    assign misroute          = misroute_r;
    assign drop_count        = drop_count_r;
    assign busy              = (state_r != ST_IDLE) | ~fifos_idle_s;

endmodule

// File: tb/tb_leaf_rx_demux.sv
// -----------------------------------------------------------------------------
// tb_leaf_rx_demux
// Directed self-checking bench for leaf_rx_demux (NUM_PORTS=4, depth 16).
// Inputs change on the falling edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_leaf_rx_demux;

    logic         clk_400;
    logic         reset_400;
    logic         ap_start;
    logic [48:0]  din_leaf_bft2interface;
    logic [127:0] dout_stream_data;
    logic [3:0]   dout_stream_valid;
    logic [3:0]   dout_stream_ready;
    logic [3:0]   overflow;
    logic         misroute;
    logic [15:0]  drop_count;
    logic         busy;

    int checks;
    int errors;

    leaf_rx_demux #(
        .NUM_PORTS  (4),
        .FIFO_DEPTH (16),
        .PAYLOAD_W  (32)
    ) dut (
        .clk_400                (clk_400),
        .reset_400              (reset_400),
        .ap_start               (ap_start),
        .din_leaf_bft2interface (din_leaf_bft2interface),
        .dout_stream_data       (dout_stream_data),
        .dout_stream_valid      (dout_stream_valid),
        .dout_stream_ready      (dout_stream_ready),
        .overflow               (overflow),
        .misroute               (misroute),
        .drop_count             (drop_count),
        .busy                   (busy)
    );

    initial clk_400 = 1'b0;
    always #5 clk_400 = ~clk_400;

    function automatic logic [48:0] mk_pkt(input logic [3:0] port, input logic [31:0] pl);
        return {1'b1, port, 12'hABC, pl};
    endfunction

    function automatic logic [31:0] port_data(input logic [127:0] bus, input int p);
        return bus[p*32 +: 32];
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_400);
    endtask

    task automatic test_reset();
        reset_400 = 1'b0;
        ap_start = 1'b0;
        din_leaf_bft2interface = 49'd0;
        dout_stream_ready = 4'b0000;
        step(3);
        checks++;
        if (dout_stream_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=%b", dout_stream_valid, 4'b0000); end
        checks++;
        if (dout_stream_data !== 128'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", dout_stream_data); end
        checks++;
        if ({overflow, misroute, drop_count, busy} !== 22'd0) begin
            errors++; $display("FAIL reset_flags ovf=%b mis=%b cnt=%0d busy=%b exp all zero", overflow, misroute, drop_count, busy);
        end
        reset_400 = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        ap_start = 1'b1;
        step(1);
        din_leaf_bft2interface = mk_pkt(4'd2, 32'hDEADBEEF);
        step(1);
        din_leaf_bft2interface = 49'd0;
        checks++;
        if (dout_stream_valid !== 4'b0000) begin errors++; $display("FAIL single_lat1 got=%b exp=%b", dout_stream_valid, 4'b0000); end
        step(1);
        checks++;
        if (dout_stream_valid !== 4'b0100) begin errors++; $display("FAIL single_lat2 got=%b exp=%b", dout_stream_valid, 4'b0100); end
        checks++;
        if (port_data(dout_stream_data, 2) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_data got=%h exp=%h", port_data(dout_stream_data, 2), 32'hDEADBEEF);
        end
        dout_stream_ready = 4'b0100;
        step(1);
        dout_stream_ready = 4'b0000;
        checks++;
        if (dout_stream_valid !== 4'b0000) begin errors++; $display("FAIL single_pop got=%b exp=%b", dout_stream_valid, 4'b0000); end
    endtask

    task automatic test_back_to_back();
        int idx [2];
        logic [31:0] exp;
        idx[0] = 0;
        idx[1] = 0;
        dout_stream_ready = 4'b0011;
        for (int c = 0; c < 24; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (dout_stream_valid[p]) begin
                    exp = 32'h1000_0000 + 32'(2 * idx[p] + p);
                    checks++;
                    if (port_data(dout_stream_data, p) !== exp) begin
                        errors++; $display("FAIL b2b_data port=%0d got=%h exp=%h", p, port_data(dout_stream_data, p), exp);
                    end
                    idx[p]++;
                end
            end
            if (c < 16) din_leaf_bft2interface = mk_pkt(4'(c % 2), 32'h1000_0000 + 32'(c));
            else        din_leaf_bft2interface = 49'd0;
            step(1);
        end
        dout_stream_ready = 4'b0000;
        checks++;
        if (idx[0] != 8 || idx[1] != 8) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=8/8", idx[0], idx[1]); end
        checks++;
        if (drop_count !== 16'd0) begin errors++; $display("FAIL b2b_drops got=%0d exp=0", drop_count); end
    endtask

    task automatic test_overflow();
        int k;
        for (int i = 0; i < 17; i++) begin
            din_leaf_bft2interface = mk_pkt(4'd3, 32'h3000_0000 + 32'(i));
            step(1);
        end
        din_leaf_bft2interface = 49'd0;
        step(2);
        checks++;
        if (overflow !== 4'b1000) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, 4'b1000); end
        checks++;
        if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drops got=%0d exp=1", drop_count); end
        k = 0;
        dout_stream_ready = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            if (dout_stream_valid[3]) begin
                checks++;
                if (port_data(dout_stream_data, 3) !== 32'h3000_0000 + 32'(k)) begin
                    errors++; $display("FAIL ovf_data k=%0d got=%h exp=%h", k, port_data(dout_stream_data, 3), 32'h3000_0000 + 32'(k));
                end
                k++;
            end
            step(1);
        end
        dout_stream_ready = 4'b0000;
        checks++;
        if (k != 16) begin errors++; $display("FAIL ovf_words got=%0d exp=16", k); end
    endtask

    task automatic test_full_pop();
        int k;
        for (int i = 0; i < 16; i++) begin
            din_leaf_bft2interface = mk_pkt(4'd0, 32'h4000_0000 + 32'(i));
            step(1);
        end
        din_leaf_bft2interface = 49'd0;
        step(2);
        din_leaf_bft2interface = mk_pkt(4'd0, 32'h4000_0010);
        step(1);
        din_leaf_bft2interface = 49'd0;
        dout_stream_ready = 4'b0001;
        step(1);
        dout_stream_ready = 4'b0000;
        checks++;
        if (overflow[0] !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b exp=0", overflow[0]); end
        checks++;
        if (drop_count !== 16'd1) begin errors++; $display("FAIL fullpop_drops got=%0d exp=1", drop_count); end
        k = 1;
        dout_stream_ready = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            if (dout_stream_valid[0]) begin
                checks++;
                if (port_data(dout_stream_data, 0) !== 32'h4000_0000 + 32'(k)) begin
                    errors++; $display("FAIL fullpop_data k=%0d got=%h exp=%h", k, port_data(dout_stream_data, 0), 32'h4000_0000 + 32'(k));
                end
                k++;
            end
            step(1);
        end
        dout_stream_ready = 4'b0000;
        checks++;
        if (k != 17) begin errors++; $display("FAIL fullpop_words got=%0d exp=16", k - 1); end
    endtask

    task automatic test_misroute_gating();
        din_leaf_bft2interface = mk_pkt(4'd5, 32'h5555_5555);
        step(1);
        din_leaf_bft2interface = 49'd0;
        step(2);
        checks++;
        if (misroute !== 1'b1) begin errors++; $display("FAIL misroute_flag got=%b exp=1", misroute); end
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL misroute_drops got=%0d exp=2", drop_count); end
        checks++;
        if (dout_stream_valid !== 4'b0000) begin errors++; $display("FAIL misroute_valid got=%b exp=0000", dout_stream_valid); end
        // RUN with bit48 clear is not a drop.
        din_leaf_bft2interface = {1'b0, 4'd7, 12'h000, 32'h7777_7777};
        step(3);
        din_leaf_bft2interface = 49'd0;
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL invalid_nodrop got=%0d exp=2", drop_count); end
        // Back to IDLE, then packets must be ignored.
        ap_start = 1'b0;
        step(3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        din_leaf_bft2interface = mk_pkt(4'd1, 32'h1111_1111);
        step(1);
        din_leaf_bft2interface = mk_pkt(4'd9, 32'h9999_9999);
        step(1);
        din_leaf_bft2interface = 49'd0;
        step(3);
        checks++;
        if (dout_stream_valid !== 4'b0000) begin errors++; $display("FAIL idle_valid got=%b exp=0000", dout_stream_valid); end
        checks++;
        if (drop_count !== 16'd2) begin errors++; $display("FAIL idle_drops got=%0d exp=2", drop_count); end
    endtask

    task automatic test_saturate();
        ap_start = 1'b1;
        step(1);
        force dut.drop_count_r = 16'hFFFE;
        step(1);
        release dut.drop_count_r;
        for (int i = 0; i < 2; i++) begin
            din_leaf_bft2interface = mk_pkt(4'd6, 32'h6666_0000 + 32'(i));
            step(1);
            din_leaf_bft2interface = 49'd0;
            step(2);
            checks++;
            if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count i=%0d got=%h exp=FFFF", i, drop_count); end
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 3; i++) begin
            din_leaf_bft2interface = mk_pkt(4'd0, 32'h5000_0000 + 32'(i));
            step(1);
        end
        din_leaf_bft2interface = 49'd0;
        step(2);
        ap_start = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy0 got=%b exp=1", busy); end
        dout_stream_ready = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b1 || port_data(dout_stream_data, 0) !== 32'h5000_0000 + 32'(k)) begin
                errors++; $display("FAIL drain_pop k=%0d busy=%b got=%h exp=%h", k, busy, port_data(dout_stream_data, 0), 32'h5000_0000 + 32'(k));
            end
            step(1);
        end
        dout_stream_ready = 4'b0000;
        step(1);
        checks++;
        if (busy !== 1'b0 || dout_stream_valid !== 4'b0000) begin
            errors++; $display("FAIL drain_idle busy=%b valid=%b exp 0/0000", busy, dout_stream_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        ap_start = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            din_leaf_bft2interface = mk_pkt(4'd0, 32'h6000_0000 + 32'(i));
            step(1);
        end
        din_leaf_bft2interface = mk_pkt(4'd3, 32'h6000_0003);
        step(1);
        din_leaf_bft2interface = 49'd0;
        step(2);
        ap_start = 1'b0;
        step(1);
        dout_stream_ready = 4'b0001;
        step(1);
        dout_stream_ready = 4'b0000;
        checks++;
        if (busy !== 1'b1 || dout_stream_valid !== 4'b1001) begin
            errors++; $display("FAIL middrain_pre busy=%b valid=%b exp 1/1001", busy, dout_stream_valid);
        end
        reset_400 = 1'b0;
        step(1);
        checks++;
        if (dout_stream_valid !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL middrain_reset valid=%b busy=%b exp 0000/0", dout_stream_valid, busy);
        end
        checks++;
        if (overflow !== 4'b0000 || misroute !== 1'b0 || drop_count !== 16'd0) begin
            errors++; $display("FAIL middrain_flags ovf=%b mis=%b cnt=%0d exp all zero", overflow, misroute, drop_count);
        end
        reset_400 = 1'b1;
        step(3);
        checks++;
        if (dout_stream_valid !== 4'b0000 || busy !== 1'b0 || dout_stream_data !== 128'd0) begin
            errors++; $display("FAIL middrain_after valid=%b busy=%b data=%h exp empty", dout_stream_valid, busy, dout_stream_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_misroute_gating();
        test_saturate();
        test_drain();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
